// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, clock deglitch filter, frame FSM with timeout, FWFT word FIFO.
// Define PS2_BREAK_DECODE_EN to fold E0/F0 prefixes into the ext/brk flags of the next pushed code.
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000,
  parameter int DEPTH       = 16,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          PS2_CLK,
  input  logic          PS2_DAT,
  input  logic          rd,
  output logic [9:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          parity_err,
  output logic          frame_err,
  output logic [1:0]    fsm_state
);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned DEPTH_U = DEPTH;
  localparam logic [AW:0] FULL_CNT = DEPTH_U[AW:0];

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          ps2c_s, ps2d_s;
  logic          filt_clk, fall;
  logic [FW-1:0] flt_cnt;
  state_t        state;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [2:0]    bit_idx;
  logic [TW-1:0] to_cnt;
  logic          abort, frame_ok, push_req, do_push, do_pop;
  logic [9:0]    push_word;
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;

  assign ps2c_s = clk_sync[1];
  assign ps2d_s = dat_sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt_clk <= 1'b1;
      flt_cnt  <= '0;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DAT};
      fall     <= 1'b0;
      if (ps2c_s == filt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        // New level reached after FILTER_LEN equal samples; a 1->0 change is the falling edge
        filt_clk <= ps2c_s;
        flt_cnt  <= '0;
        fall     <= filt_clk;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign abort    = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign frame_ok = (state == STOP) && fall && ps2d_s && ((^shreg) ^ par_bit);

`ifdef PS2_BREAK_DECODE_EN
  logic pend_ext, pend_brk, is_prefix, bad_frame;
  assign is_prefix = (shreg == 8'hE0) || (shreg == 8'hF0);
  assign bad_frame = (state == STOP) && fall && !frame_ok;
  assign push_req  = frame_ok && !is_prefix;
  assign push_word = {pend_ext, pend_brk, shreg};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
    end else if (abort || bad_frame || push_req) begin
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
    end else if (frame_ok) begin
      if (shreg == 8'hE0) pend_ext <= 1'b1;
      else                pend_brk <= 1'b1;
    end
  end
`else
  assign push_req  = frame_ok;
  assign push_word = {2'b00, shreg};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      par_bit    <= 1'b0;
      bit_idx    <= '0;
      to_cnt     <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        shreg     <= '0;
        to_cnt    <= '0;
        frame_err <= 1'b1;
      end else begin
        if (state != IDLE) to_cnt <= fall ? '0 : to_cnt + 1'b1;
        if (fall) begin
          case (state)
            IDLE: if (!ps2d_s) begin
              state   <= DATA;
              bit_idx <= '0;
              to_cnt  <= '0;
            end
            DATA: begin
              shreg   <= {ps2d_s, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) state <= PARITY;
            end
            PARITY: begin
              par_bit <= ps2d_s;
              state   <= STOP;
            end
            STOP: begin
              state <= IDLE;
              if (!ps2d_s)                   frame_err  <= 1'b1;
              else if (!((^shreg) ^ par_bit)) parity_err <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign fsm_state = state;

  // rd pops the head word; empty=1 means dout is not valid and rd is ignored.
  assign do_pop  = rd && !empty;
  assign do_push = push_req && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= push_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_req && full && !do_pop;
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);
  assign dout  = empty ? 10'd0 : mem[rp];
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed and randomized frame stimulus for ps2_rx_fifo, checked against a byte-level decode/FIFO model.
module tb_ps2_rx_fifo;
  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 300;
  localparam int DEPTH       = 4;
  localparam int AW          = 2;
  localparam int HALF        = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic        rd = 1'b0;
  logic [9:0]  dout;
  logic        empty, full, overflow, parity_err, frame_err;
  logic [AW:0] count;
  logic [1:0]  fsm_state;

  ps2_rx_fifo #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat), .rd(rd),
    .dout(dout), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitors
  int   pe_seen = 0, fe_seen = 0, ov_seen = 0;
  int   empty_fall_cyc = 0, stop_fall_cyc = 0;
  logic prev_empty = 1'b1;
  always @(negedge clk) begin
    if (parity_err === 1'b1) pe_seen <= pe_seen + 1;
    if (frame_err === 1'b1)  fe_seen <= fe_seen + 1;
    if (overflow === 1'b1)   ov_seen <= ov_seen + 1;
    if (prev_empty && !empty) empty_fall_cyc <= cyc;
    prev_empty <= empty;
  end

  // scoreboard
  logic [9:0] exp_q[$];
  int exp_pe = 0, exp_fe = 0, exp_ov = 0;
  int n_cmp = 0, n_fail = 0;
`ifdef PS2_BREAK_DECODE_EN
  bit pend_ext = 0, pend_brk = 0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_discard();
`ifdef PS2_BREAK_DECODE_EN
    pend_ext = 0;
    pend_brk = 0;
`endif
  endtask

  task automatic model_accept(input logic [7:0] b);
    logic [9:0] w;
`ifdef PS2_BREAK_DECODE_EN
    if (b == 8'hE0) begin pend_ext = 1; return; end
    if (b == 8'hF0) begin pend_brk = 1; return; end
    w = {pend_ext, pend_brk, b};
    model_discard();
`else
    w = {2'b00, b};
`endif
    if (exp_q.size() >= DEPTH) exp_ov++;
    else exp_q.push_back(w);
  endtask

  // driver tasks
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit pop_at_push, input int nbits);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_dat = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) stop_fall_cyc = cyc;
      if (i == 10 && pop_at_push) begin
        repeat (FILTER_LEN + 2) @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        repeat (HALF - FILTER_LEN - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_dat = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_model(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_frame(b, bad_par, bad_stop, 1'b0, 11);
    if (bad_stop) begin exp_fe++; model_discard(); end
    else if (bad_par) begin exp_pe++; model_discard(); end
    else model_accept(b);
  endtask

  task automatic pop_one();
    @(negedge clk);
    check("head_empty", empty, 0);
    check("head_dout", dout, exp_q[0]);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    void'(exp_q.pop_front());
    check("pop_count", count, exp_q.size());
  endtask

  task automatic drain();
    while (exp_q.size() > 0) pop_one();
    check("drained_empty", empty, 1);
  endtask

  task automatic check_pulses(input string tag);
    check({tag, "_parity_err"}, pe_seen, exp_pe);
    check({tag, "_frame_err"}, fe_seen, exp_fe);
    check({tag, "_overflow"}, ov_seen, exp_ov);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_pulses"}, {overflow, parity_err, frame_err}, 0);
    check({tag, "_fsm_idle"}, fsm_state, 0);
  endtask

  logic [7:0] b;
  int kind;

  initial begin
    repeat (5) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // single key press and end-to-end latency
    send_model(8'h1C, 0, 0);
    check("latency", empty_fall_cyc - stop_fall_cyc, FILTER_LEN + 3);
    check("press_count", count, 1);
    drain();

    // prefix sequence
    send_model(8'hE0, 0, 0);
    send_model(8'hF0, 0, 0);
    send_model(8'h75, 0, 0);
    check("prefix_count", count, exp_q.size());
    drain();

    // parity error then recovery
    send_model(8'h1C, 1, 0);
    check("par_err_count", count, 0);
    check_pulses("par");
    send_model(8'h29, 0, 0);
    drain();

    // stalled frame hits the timeout
    send_frame(8'hA5, 0, 0, 0, 5);
    repeat (TIMEOUT_CYC + 10) @(negedge clk);
    exp_fe++;
    model_discard();
    check_pulses("stall");
    check("stall_idle", fsm_state, 0);
    send_model(8'h5A, 0, 0);
    drain();

    // fill past capacity, then a pop coincident with a push
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hE0 || b == 8'hF0) b = b ^ 8'h01;
      send_model(b, 0, 0);
    end
    check("full_flag", full, 1);
    check("full_count", count, DEPTH);
    check_pulses("full");
    @(negedge clk);
    check("full_head", dout, exp_q[0]);
    b = 8'h6B;
    send_frame(b, 0, 0, 1'b1, 11);
    void'(exp_q.pop_front());
    model_accept(b);
    check("pushpop_count", count, DEPTH);
    check_pulses("pushpop");
    drain();

    // short clock glitch with data low must not start a frame
    @(negedge clk);
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    ps2_dat = 1'b1;
    check("glitch_idle", fsm_state, 0);
    check("glitch_count", count, 0);
    send_model(8'h3C, 0, 0);
    drain();
    check_pulses("glitch");

    // randomized frames with corruptions and random pops
    for (int i = 0; i < 12; i++) begin
      kind = $urandom_range(0, 7);
      if (kind == 0) b = 8'hE0;
      else if (kind == 1) b = 8'hF0;
      else if (kind == 2) b = 8'hE1;
      else b = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 9);
      send_model(b, kind == 0, kind == 1);
      check("rand_count", count, exp_q.size());
      if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) pop_one();
    end
    check_pulses("rand");
    drain();

    // reset in the middle of a frame with a non-empty FIFO
    send_model(8'h33, 0, 0);
    send_frame(8'h81, 0, 0, 0, 6);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_vals("midreset");
    exp_q.delete();
    model_discard();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    send_model(8'h4D, 0, 0);
    drain();
    check_pulses("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
